// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit: fetch FSM states and
// instruction constants.
package instr_fetch_unit_pkg;

  localparam int unsigned INSTR_OPCODE_WIDTH = 7;
  localparam logic [31:0] INSTR_NOP          = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory channel: valid/ready request, valid-only response.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imemReqValid;
  logic            imemReqReady;
  logic [XLEN-1:0] imemAddr;
  logic            imemRspValid;
  logic [XLEN-1:0] imemRspData;

  modport master (
    output imemReqValid,
    output imemAddr,
    input  imemReqReady,
    input  imemRspValid,
    input  imemRspData
  );

  modport slave (
    input  imemReqValid,
    input  imemAddr,
    output imemReqReady,
    output imemRspValid,
    output imemRspData
  );
endinterface

// File: rtl/fetch_timeout_counter.sv
// Cycle counter bounding the time a fetch may spend in REQ+WAIT.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires during the last permitted cycle so the abort lands exactly
  // TIMEOUT_CYCLES cycles after entering REQ.
  assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter / instruction register owner; fetches one instruction per
// IRWrite request and stalls the controller via fetchBusy.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          PCWrite,
  input  logic                          IRWrite,
  input  logic [XLEN-1:0]               pcNext,
  instr_fetch_unit_if.master            imem,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               instr,
  output logic [INSTR_OPCODE_WIDTH-1:0] opCode,
  output logic                          fetchBusy,
  output logic                          fetchErr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            err_q, err_d;
  logic            tmo_clear, tmo_enable, tmo_expired;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  assign tmo_clear  = (state_q == StIdle) && IRWrite;
  assign tmo_enable = (state_q == StReq) || (state_q == StWait);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        // A same-cycle PCWrite lands before REQ, so the fetch uses the new PC.
        if (PCWrite) begin
          if (pcNext[1:0] == 2'b00) begin
            pc_d = pcNext;
          end else begin
            err_d = 1'b1;
          end
        end
        if (IRWrite) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (tmo_expired) begin
          err_d   = 1'b1;
          instr_d = XLEN'(INSTR_NOP);
          state_d = StDone;
        end else if (imem.imemReqReady) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (tmo_expired) begin
          err_d   = 1'b1;
          instr_d = XLEN'(INSTR_NOP);
          state_d = StDone;
        end else if (imem.imemRspValid) begin
          instr_d = imem.imemRspData;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= XLEN'(INSTR_NOP);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Request is a pure function of state, so reset drops it asynchronously.
  assign imem.imemReqValid = (state_q == StReq);
  assign imem.imemAddr     = pc_q;

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opCode    = instr_q[INSTR_OPCODE_WIDTH-1:0];
  assign fetchErr  = err_q;
  assign fetchBusy = (state_q == StReq) || (state_q == StWait) ||
                     ((state_q == StIdle) && IRWrite);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table-driven cycle vectors plus
// hand-written timeout and reset sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PCWrite, IRWrite;
  logic [31:0] pcNext;
  logic [31:0] pc, instr;
  logic [6:0]  opCode;
  logic        fetchBusy, fetchErr;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit_if #(.XLEN(32)) imem ();

  instr_fetch_unit #(
    .XLEN          (32),
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .pcNext   (pcNext),
    .imem     (imem),
    .pc       (pc),
    .instr    (instr),
    .opCode   (opCode),
    .fetchBusy(fetchBusy),
    .fetchErr (fetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        pcw;
    logic        irw;
    logic [31:0] pcn;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [6:0]  e_op;
    logic        e_err;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic irw, input logic [31:0] pcn,
                       input logic rdy, input logic rspv, input logic [31:0] rspd);
    PCWrite           = pcw;
    IRWrite           = irw;
    pcNext            = pcn;
    imem.imemReqReady = rdy;
    imem.imemRspValid = rspv;
    imem.imemRspData  = rspd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Zero-wait fetch starting from IDLE; ends back in IDLE.
  task automatic do_fetch(input logic [31:0] data);
    drive(0, 1, 0, 0, 0, 0);    tick();
    drive(0, 0, 0, 1, 0, 0);    tick();
    drive(0, 0, 0, 0, 1, data); tick();
    drive(0, 0, 0, 0, 0, 0);    tick();
  endtask

  initial begin
    // pcw irw pcNext rdy rspv rspData | rv addr busy pc instr op err
    vecs[0]  = '{0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, NOP,          7'h13, 0};
    vecs[1]  = '{0, 1, 32'h0, 0, 0, 32'h0,         0, 32'h0, 1, 32'h0, NOP,          7'h13, 0};
    vecs[2]  = '{0, 1, 32'h0, 1, 0, 32'h0,         1, 32'h0, 1, 32'h0, NOP,          7'h13, 0};
    vecs[3]  = '{0, 1, 32'h0, 0, 1, 32'h0050_0093, 0, 32'h0, 1, 32'h0, NOP,          7'h13, 0};
    vecs[4]  = '{0, 1, 32'h0, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0050_0093, 7'h13, 0};
    vecs[5]  = '{0, 0, 32'h0, 0, 1, 32'hffff_ffff, 0, 32'h0, 0, 32'h0, 32'h0050_0093, 7'h13, 0};
    vecs[6]  = '{1, 0, 32'h4, 0, 0, 32'h0,         0, 32'h0, 0, 32'h0, 32'h0050_0093, 7'h13, 0};
    vecs[7]  = '{0, 1, 32'h0, 0, 0, 32'h0,         0, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[8]  = '{0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[9]  = '{1, 0, 32'h8, 0, 0, 32'h0,         1, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[10] = '{0, 0, 32'h0, 0, 1, 32'hdead_beef, 1, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[11] = '{0, 0, 32'h0, 0, 0, 32'h0,         1, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[12] = '{0, 0, 32'h0, 1, 0, 32'h0,         1, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[13] = '{0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[14] = '{0, 0, 32'h0, 0, 1, 32'h1234_50b7, 0, 32'h4, 1, 32'h4, 32'h0050_0093, 7'h13, 0};
    vecs[15] = '{0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h4, 0, 32'h4, 32'h1234_50b7, 7'h37, 0};
    vecs[16] = '{1, 0, 32'h6, 0, 0, 32'h0,         0, 32'h4, 0, 32'h4, 32'h1234_50b7, 7'h37, 0};
    vecs[17] = '{0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h4, 0, 32'h4, 32'h1234_50b7, 7'h37, 1};
    vecs[18] = '{1, 0, 32'h10, 0, 0, 32'h0,        0, 32'h4, 0, 32'h4, 32'h1234_50b7, 7'h37, 1};
    vecs[19] = '{0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h10, 0, 32'h10, 32'h1234_50b7, 7'h37, 1};

    // Reset state, checked while reset is still asserted.
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_reqvalid", {31'b0, imem.imemReqValid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_err", {31'b0, fetchErr}, 32'h0);
    chk("rst_busy", {31'b0, fetchBusy}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].pcw, vecs[i].irw, vecs[i].pcn, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd);
      @(negedge clk);
      chk($sformatf("v%0d_reqvalid", i), {31'b0, imem.imemReqValid}, {31'b0, vecs[i].e_rv});
      chk($sformatf("v%0d_addr", i), imem.imemAddr, vecs[i].e_addr);
      chk($sformatf("v%0d_busy", i), {31'b0, fetchBusy}, {31'b0, vecs[i].e_busy});
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d_opcode", i), {25'b0, opCode}, {25'b0, vecs[i].e_op});
      chk($sformatf("v%0d_err", i), {31'b0, fetchErr}, {31'b0, vecs[i].e_err});
      tick();
    end

    // Timeout: memory accepts but never responds; abort after 8 cycles in REQ+WAIT.
    do_reset();
    do_fetch(32'h0010_0537);
    chk("pre_tmo_instr", instr, 32'h0010_0537);
    drive(0, 1, 0, 0, 0, 0); tick();
    for (int c = 1; c <= 8; c++) begin
      drive(0, 0, 0, (c == 1), 0, 0);
      @(negedge clk);
      chk($sformatf("tmo_c%0d_busy", c), {31'b0, fetchBusy}, 32'h1);
      chk($sformatf("tmo_c%0d_err", c), {31'b0, fetchErr}, 32'h0);
      tick();
    end
    @(negedge clk);
    chk("tmo_done_busy", {31'b0, fetchBusy}, 32'h0);
    chk("tmo_done_err", {31'b0, fetchErr}, 32'h1);
    chk("tmo_done_instr", instr, NOP);
    tick();
    drive(0, 0, 0, 0, 1, 32'hcafe_f00d);
    repeat (3) tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tmo_late_rsp_instr", instr, NOP);
    chk("tmo_idle_busy", {31'b0, fetchBusy}, 32'h0);
    chk("tmo_err_sticky", {31'b0, fetchErr}, 32'h1);
    tick();

    // Reset while a request is stalled: reqValid drops without a clock edge.
    drive(1, 0, 32'h20, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0);      tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("stall_reqvalid", {31'b0, imem.imemReqValid}, 32'h1);
    chk("stall_addr", imem.imemAddr, 32'h20);
    rst_n = 1'b0;
    #1;
    chk("async_rst_reqvalid", {31'b0, imem.imemReqValid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset while in WAIT, then a stale response after release.
    drive(1, 0, 32'h20, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);      tick();
    drive(1, 0, 32'h7, 0, 0, 0);  tick();
    drive(0, 1, 0, 0, 0, 0);      tick();
    drive(0, 0, 0, 1, 0, 0);      tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("wait_busy", {31'b0, fetchBusy}, 32'h1);
    chk("wait_pc", pc, 32'h20);
    chk("wait_err", {31'b0, fetchErr}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("wrst_reqvalid", {31'b0, imem.imemReqValid}, 32'h0);
    chk("wrst_pc", pc, 32'h0);
    chk("wrst_instr", instr, NOP);
    chk("wrst_err", {31'b0, fetchErr}, 32'h0);
    chk("wrst_busy", {31'b0, fetchBusy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h0badc0de);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stale_rsp_instr", instr, NOP);
    chk("stale_rsp_busy", {31'b0, fetchBusy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
